axil_reg_slave: RTL and testbench
=================================

# axil_reg_slave

AXI-Lite responder that terminates one interconnect master-side port (`m_axil[i]`) with a bank of `NUM_REGS` read/write 32-bit control registers. It accepts single-beat writes and reads, applies byte strobes, returns OKAY/error responses, and exposes the register contents as a flat vector to user logic. It is the slave-side counterpart of the interconnect's initiator ports and is the default endpoint for control/status space.

## Interface
- `ADDR_WIDTH`, 32, AXI-Lite address width.
- `DATA_WIDTH`, 32, data width; only 32 is supported.
- `NUM_REGS`, 16, number of registers; power of two, 2..256.

Ports:
- `aclk`  in  1  clock.
- `areset`  in  1  synchronous, active-high reset.
- `s_axil_awaddr`  in  ADDR_WIDTH  write address. `s_axil_awvalid` in 1. `s_axil_awready` out 1.
- `s_axil_wdata`  in  32  write data. `s_axil_wstrb` in 4. `s_axil_wvalid` in 1. `s_axil_wready` out 1.
- `s_axil_bresp`  out  2  write response. `s_axil_bvalid` out 1. `s_axil_bready` in 1.
- `s_axil_araddr`  in  ADDR_WIDTH  read address. `s_axil_arvalid` in 1. `s_axil_arready` out 1.
- `s_axil_rdata`  out  32  read data. `s_axil_rresp` out 2. `s_axil_rvalid` out 1. `s_axil_rready` in 1.
- `regs_o`  out  NUM_REGS*32  register contents; reg k at bits [32k+31:32k].
- `wr_pulse_o`  out  NUM_REGS  one-cycle pulse on the cycle after reg k is written.

## Operation
- Index = `addr[log2(NUM_REGS)+1:2]`; `addr[1:0]` ignored. Address in range iff `addr[ADDR_WIDTH-1:log2(NUM_REGS)+2] == 0`.
- Write path: AW and W are captured independently into one-entry holding registers, in either order or the same cycle. `awready = !aw_held && !bvalid`; `wready = !w_held && !bvalid`.
- When both are held (or arrive together), write executes next edge: each byte `b` with `wstrb[b]=1` updated; `wstrb=0` is a legal no-op returning OKAY. Out of range: no register changes, `bresp` = error code.
- `bvalid` held with stable `bresp` until `bready`; holding registers clear on the write, so next AW/W accepted after B handshake.
- Read path: `arready = !rvalid`. On AR handshake, `rdata` = register value before that edge (in range) or 0 with error `rresp`; held stable until `rready`.
- Read and write paths are fully independent; a same-cycle read of a register being written returns the old value.
- Reset: all registers 0, `regs_o`=0, `wr_pulse_o`=0, holding registers empty, `bvalid`=`rvalid`=0, `bresp`=`rresp`=0, `rdata`=0, `awready`=`wready`=`arready`=1 from the first cycle after reset deasserts (0 while `areset`=1). Reset mid-transaction abandons it; no response is issued.

## Timing
- Write: last of AW/W handshakes at edge N → register and `wr_pulse_o` updated, `bvalid`=1 at N+1. With `bready`=1: sustained 1 write per 2 cycles.
- Read: AR handshake at edge N → `rvalid`=1, `rdata` valid at N+1. With `rready`=1: 1 read per 2 cycles.
- `bready`/`rready` low: response held indefinitely; no new address on that path accepted.

## Configuration
- `AXIL_REG_SLAVE_DECERR_EN` defined: out-of-range access responds DECERR (2'b11).
- Undefined: out-of-range access responds SLVERR (2'b10). In-range always OKAY (2'b00).

## Test plan
- Reset, then write 0xDEADBEEF to 0x04 with `wstrb`=4'hF, AW and W same cycle → `bvalid` next cycle, `bresp`=0, `regs_o[63:32]`=0xDEADBEEF, `wr_pulse_o[1]` pulses once.
- W 0x000000AA `wstrb`=4'h1 two cycles before AW 0x04 → reg1 = 0xDEADBEAA; AW before W ordering gives same result.
- Read 0x04 with `rready` low for 5 cycles → `rvalid` held, `rdata`=0xDEADBEAA stable, `arready`=0 until handshake.
- Write/read 0x40 (NUM_REGS=16) → `bresp`/`rresp`=2'b10 (2'b11 with macro), `rdata`=0, no register changed.
- Same-cycle write 0x11111111 and read of reg 2 (old 0) → `rdata`=0; subsequent read returns 0x11111111.
- Assert `areset` while `bvalid` pending → `bvalid`=0, all `regs_o`=0 next cycle.

Source files
------------

// File: rtl/axil_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axil_reg_slave
//  Purpose  : AXI-Lite responder backed by a bank of NUM_REGS 32-bit
//             read/write control registers. Single-beat reads and writes,
//             byte strobes, OKAY / error responses, flat register export.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    aclk, areset          clock, synchronous active-high reset
//    s_axil_aw*            write address channel (addr, valid, ready)
//    s_axil_w*             write data channel (data, strb, valid, ready)
//    s_axil_b*             write response channel (resp, valid, ready)
//    s_axil_ar*            read address channel (addr, valid, ready)
//    s_axil_r*             read data channel (data, resp, valid, ready)
//    regs_o                register k at bits [32k+31:32k]
//    wr_pulse_o            bit k pulses for one cycle after reg k is written
//  Configuration
//    AXIL_REG_SLAVE_DECERR_EN  defined  : out-of-range access returns DECERR
//                              undefined: out-of-range access returns SLVERR
// ============================================================================
module axil_reg_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,   // only 32 is supported
    parameter int NUM_REGS   = 16    // power of two, 2..256
) (
    input  logic                           aclk,
    input  logic                           areset,
    // write address
    input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
    input  logic                           s_axil_awvalid,
    output logic                           s_axil_awready,
    // write data
    input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axil_wstrb,
    input  logic                           s_axil_wvalid,
    output logic                           s_axil_wready,
    // write response
    output logic [1:0]                     s_axil_bresp,
    output logic                           s_axil_bvalid,
    input  logic                           s_axil_bready,
    // read address
    input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
    input  logic                           s_axil_arvalid,
    output logic                           s_axil_arready,
    // read data
    output logic [DATA_WIDTH-1:0]          s_axil_rdata,
    output logic [1:0]                     s_axil_rresp,
    output logic                           s_axil_rvalid,
    input  logic                           s_axil_rready,
    // user side
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int         c_idx_w  = $clog2(NUM_REGS);
    localparam int         c_strb_w = DATA_WIDTH / 8;
    localparam logic [1:0] c_resp_ok = 2'b00;
`ifdef AXIL_REG_SLAVE_DECERR_EN
    localparam logic [1:0] c_resp_err = 2'b11;
`else
    localparam logic [1:0] c_resp_err = 2'b10;
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_wr_pulse;

    logic                  r_aw_held;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic                  r_w_held;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [c_strb_w-1:0]   r_w_strb;

    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;

    // ------------------------------------------------------------------------
    // Handshakes and write-execute decision
    // ------------------------------------------------------------------------
    logic                  w_aw_hs, w_w_hs, w_ar_hs;
    logic                  w_do_write;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [c_strb_w-1:0]   w_wr_strb;
    logic [c_idx_w-1:0]    w_wr_idx, w_rd_idx;
    logic                  w_wr_in_range, w_rd_in_range;
    logic                  w_unused_addr_lsbs;

    // Ready is forced low during reset so nothing is accepted before the
    // first cycle after reset deasserts.
    assign s_axil_awready = !areset && !r_aw_held && !r_bvalid;
    assign s_axil_wready  = !areset && !r_w_held  && !r_bvalid;
    assign s_axil_arready = !areset && !r_rvalid;

    assign w_aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_w_hs  = s_axil_wvalid  && s_axil_wready;
    assign w_ar_hs = s_axil_arvalid && s_axil_arready;

    // A channel is "available" if it is held or handshaking this cycle; the
    // write fires on the edge where both become available.
    assign w_do_write = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

    assign w_wr_addr = r_aw_held ? r_aw_addr : s_axil_awaddr;
    assign w_wr_data = r_w_held  ? r_w_data  : s_axil_wdata;
    assign w_wr_strb = r_w_held  ? r_w_strb  : s_axil_wstrb;

    assign w_wr_idx      = w_wr_addr[c_idx_w+1:2];
    assign w_wr_in_range = (w_wr_addr[ADDR_WIDTH-1:c_idx_w+2] == '0);
    assign w_rd_idx      = s_axil_araddr[c_idx_w+1:2];
    assign w_rd_in_range = (s_axil_araddr[ADDR_WIDTH-1:c_idx_w+2] == '0);

    // Byte-offset bits carry no meaning for word registers.
    assign w_unused_addr_lsbs = ^{w_wr_addr[1:0], s_axil_araddr[1:0]};

    // ------------------------------------------------------------------------
    // Write holding registers and response
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_aw_held <= 1'b0;
            r_aw_addr <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_resp_ok;
        end else begin
            if (w_do_write) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_in_range ? c_resp_ok : c_resp_err;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_addr <= s_axil_awaddr;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_w_data <= s_axil_wdata;
                    r_w_strb <= s_axil_wstrb;
                end
                if (r_bvalid && s_axil_bready) begin
                    r_bvalid <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Register bank. The write pulse fires for any in-range write, including
    // an all-zero strobe, so user logic sees every access to its register.
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_do_write && w_wr_in_range) begin
                for (int b = 0; b < c_strb_w; b++) begin
                    if (w_wr_strb[b]) begin
                        r_regs[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
                    end
                end
                r_wr_pulse[w_wr_idx] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read path. Sampling r_regs here yields the pre-edge value, so a read
    // racing a write to the same register returns the old contents.
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rvalid <= 1'b0;
            r_rresp  <= c_resp_ok;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_in_range ? c_resp_ok : c_resp_err;
            r_rdata  <= w_rd_in_range ? r_regs[w_rd_idx] : '0;
        end else if (r_rvalid && s_axil_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign s_axil_bvalid = r_bvalid;
    assign s_axil_bresp  = r_bresp;
    assign s_axil_rvalid = r_rvalid;
    assign s_axil_rresp  = r_rresp;
    assign s_axil_rdata  = r_rdata;
    assign wr_pulse_o    = r_wr_pulse;

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
            assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axil_reg_slave
//  Purpose  : Directed self-checking bench for axil_reg_slave (16 regs).
//             Honours AXIL_REG_SLAVE_DECERR_EN for the expected error code.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axil_reg_slave;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_REGS   = 16;
`ifdef AXIL_REG_SLAVE_DECERR_EN
    localparam logic [1:0] c_err = 2'b11;
`else
    localparam logic [1:0] c_err = 2'b10;
`endif

    logic                           aclk;
    logic                           areset;
    logic [ADDR_WIDTH-1:0]          awaddr;
    logic                           awvalid, awready;
    logic [DATA_WIDTH-1:0]          wdata;
    logic [3:0]                     wstrb;
    logic                           wvalid, wready;
    logic [1:0]                     bresp;
    logic                           bvalid, bready;
    logic [ADDR_WIDTH-1:0]          araddr;
    logic                           arvalid, arready;
    logic [DATA_WIDTH-1:0]          rdata;
    logic [1:0]                     rresp;
    logic                           rvalid, rready;
    logic [NUM_REGS*DATA_WIDTH-1:0] regs;
    logic [NUM_REGS-1:0]            wr_pulse;

    logic [31:0] exp_regs [NUM_REGS];
    int          n_checks = 0;
    int          n_errors = 0;

    axil_reg_slave #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_dut (
        .aclk           (aclk),
        .areset         (areset),
        .s_axil_awaddr  (awaddr),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .regs_o         (regs),
        .wr_pulse_o     (wr_pulse)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < NUM_REGS; k++) begin
            check($sformatf("%s reg%0d", tag, k), regs[k*32 +: 32], exp_regs[k]);
        end
    endtask

    // AW and W presented in the same cycle; leaves bvalid pending.
    task automatic write_both(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        check("awready before write", {31'b0, awready}, 32'd1);
        check("wready before write",  {31'b0, wready},  32'd1);
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid after write", {31'b0, bvalid}, 32'd1);
    endtask

    task automatic finish_b();
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bvalid cleared", {31'b0, bvalid}, 32'd0);
    endtask

    // AR handshake; leaves rvalid pending.
    task automatic read_addr(input logic [31:0] addr);
        check("arready before read", {31'b0, arready}, 32'd1);
        araddr = addr; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("rvalid after read", {31'b0, rvalid}, 32'd1);
    endtask

    task automatic finish_r();
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rvalid cleared", {31'b0, rvalid}, 32'd0);
    endtask

    initial begin
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = 32'h0;

        // ---------------- reset ----------------
        areset = 1'b1;
        repeat (3) tick();
        check("awready in reset", {31'b0, awready}, 32'd0);
        check("arready in reset", {31'b0, arready}, 32'd0);
        areset = 1'b0;
        tick();
        check("reset bvalid",   {31'b0, bvalid}, 32'd0);
        check("reset rvalid",   {31'b0, rvalid}, 32'd0);
        check("reset rdata",    rdata, 32'h0);
        check("reset bresp",    {30'b0, bresp}, 32'd0);
        check("reset wr_pulse", {16'b0, wr_pulse}, 32'h0);
        check("reset arready",  {31'b0, arready}, 32'd1);
        check_regs("reset");

        // ---------------- full write, same cycle ----------------
        write_both(32'h04, 32'hDEADBEEF, 4'hF);
        exp_regs[1] = 32'hDEADBEEF;
        check("wr1 bresp",    {30'b0, bresp}, 32'd0);
        check("wr1 pulse",    {16'b0, wr_pulse}, 32'h0002);
        check("wr1 awready held off", {31'b0, awready}, 32'd0);
        check_regs("wr1");
        finish_b();
        check("wr1 pulse once", {16'b0, wr_pulse}, 32'h0000);

        // ---------------- W two cycles before AW ----------------
        wdata = 32'h000000AA; wstrb = 4'h1; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("wfirst wready held", {31'b0, wready}, 32'd0);
        check("wfirst no bvalid",   {31'b0, bvalid}, 32'd0);
        tick();
        check("wfirst reg1 unchanged", regs[63:32], 32'hDEADBEEF);
        awaddr = 32'h04; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        exp_regs[1] = 32'hDEADBEAA;
        check("wfirst bvalid", {31'b0, bvalid}, 32'd1);
        check("wfirst bresp",  {30'b0, bresp}, 32'd0);
        check("wfirst pulse",  {16'b0, wr_pulse}, 32'h0002);
        check_regs("wfirst");
        finish_b();

        // ---------------- AW before W (reg 3) ----------------
        write_both(32'h0C, 32'hDEADBEEF, 4'hF);
        finish_b();
        awaddr = 32'h0C; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("awfirst awready held", {31'b0, awready}, 32'd0);
        check("awfirst no bvalid",    {31'b0, bvalid}, 32'd0);
        wdata = 32'h000000AA; wstrb = 4'h1; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        exp_regs[3] = 32'hDEADBEAA;
        check("awfirst bvalid", {31'b0, bvalid}, 32'd1);
        check("awfirst pulse",  {16'b0, wr_pulse}, 32'h0008);
        check_regs("awfirst");
        finish_b();

        // ---------------- zero strobe is a no-op with OKAY ----------------
        write_both(32'h0C, 32'hFFFFFFFF, 4'h0);
        check("strb0 bresp", {30'b0, bresp}, 32'd0);
        check_regs("strb0");
        finish_b();

        // ---------------- read with back-pressure ----------------
        read_addr(32'h04);
        check("rd1 rdata", rdata, 32'hDEADBEAA);
        check("rd1 rresp", {30'b0, rresp}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rd1 hold rvalid c%0d", i), {31'b0, rvalid}, 32'd1);
            check($sformatf("rd1 hold rdata c%0d", i), rdata, 32'hDEADBEAA);
            check($sformatf("rd1 hold arready c%0d", i), {31'b0, arready}, 32'd0);
        end
        finish_r();
        check("rd1 arready after", {31'b0, arready}, 32'd1);

        // ---------------- out of range ----------------
        write_both(32'h40, 32'hFFFFFFFF, 4'hF);
        check("oor bresp", {30'b0, bresp}, {30'b0, c_err});
        check("oor no pulse", {16'b0, wr_pulse}, 32'h0000);
        check_regs("oor");
        tick();
        check("oor bresp stable", {30'b0, bresp}, {30'b0, c_err});
        finish_b();
        read_addr(32'h40);
        check("oor rdata", rdata, 32'h0);
        check("oor rresp", {30'b0, rresp}, {30'b0, c_err});
        finish_r();

        // ---------------- same-cycle write and read of reg 2 ----------------
        awaddr = 32'h08; awvalid = 1'b1;
        wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 32'h08; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        exp_regs[2] = 32'h11111111;
        check("race rvalid", {31'b0, rvalid}, 32'd1);
        check("race rdata old", rdata, 32'h0);
        check("race bvalid", {31'b0, bvalid}, 32'd1);
        check_regs("race");
        finish_b();
        finish_r();
        read_addr(32'h08);
        check("race reread", rdata, 32'h11111111);
        finish_r();

        // ---------------- reset with response pending ----------------
        write_both(32'h00, 32'h12345678, 4'hF);
        exp_regs[0] = 32'h12345678;
        check_regs("pre-reset");
        areset = 1'b1;
        tick();
        for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = 32'h0;
        check("midreset bvalid",   {31'b0, bvalid}, 32'd0);
        check("midreset pulse",    {16'b0, wr_pulse}, 32'h0);
        check("midreset awready",  {31'b0, awready}, 32'd0);
        check_regs("midreset");
        areset = 1'b0;
        tick();
        check("post-reset awready", {31'b0, awready}, 32'd1);
        check("post-reset wready",  {31'b0, wready},  32'd1);
        check("post-reset bvalid",  {31'b0, bvalid},  32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
